// File: rtl/fpu_pkg.sv
// fpu_pkg: shared issue-FSM state encoding and FPU word-format constants
package fpu_pkg;
  localparam int FPU_W    = 32;
  localparam int EXP_W    = 6;
  localparam int MAN_W    = 25;
  localparam int EXP_BIAS = 31;
  localparam int STATUS_W = 4;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_HOLD} state_t;
endpackage

// File: rtl/fpu_operand_fifo.sv
// fpu_operand_fifo: synchronous operand-pair queue with full/empty/count
module fpu_operand_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          w_push, w_pop;
  assign full   = r_cnt == (AW+1)'(DEPTH);
  assign empty  = r_cnt == '0;
  assign count  = r_cnt;
  assign rdata  = r_mem[r_rp];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  always_ff @(posedge clock)
    if (w_push) r_mem[r_wp] <= wdata;
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_wp  <= w_push ? r_wp + 1'b1 : r_wp;
      r_rp  <= w_pop ? r_rp + 1'b1 : r_rp;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: queues operand pairs, pulses FPU reset per op, captures results.
// Optional sticky status accumulator enabled by FPU_ISSUE_STICKY_EN.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int FPU_LATENCY = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [FPU_W-1:0]    in_op_a,
  input  logic [FPU_W-1:0]    in_op_b,
  output logic                fpu_reset,
  output logic [FPU_W-1:0]    fpu_op_a,
  output logic [FPU_W-1:0]    fpu_op_b,
  input  logic [FPU_W-1:0]    fpu_data,
  input  logic [STATUS_W-1:0] fpu_status,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [FPU_W-1:0]    out_data,
  output logic [STATUS_W-1:0] out_status,
  output logic                busy
`ifdef FPU_ISSUE_STICKY_EN
  ,
  output logic [STATUS_W-1:0] sticky_status,
  input  logic                sticky_clr
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic                w_full, w_empty, w_pop, w_hs;
  logic [CW-1:0]       w_count;
  logic [2*FPU_W-1:0]  w_head;
  state_t              r_state;
  logic [7:0]          r_cnt;
  logic                r_fpu_rst, r_out_valid;
  logic [FPU_W-1:0]    r_op_a, r_op_b, r_out_data;
  logic [STATUS_W-1:0] r_out_status;
  fpu_operand_fifo #(.W(2*FPU_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock(clock), .reset(reset), .push(in_valid), .pop(w_pop),
    .wdata({in_op_a, in_op_b}), .rdata(w_head),
    .full(w_full), .empty(w_empty), .count(w_count)
  );
  assign w_hs       = r_out_valid && out_ready;
  assign w_pop      = !w_empty && (r_state == S_IDLE || (r_state == S_HOLD && out_ready));
  assign in_ready   = !w_full;
  assign busy       = r_state != S_IDLE || w_count != '0;
  assign fpu_reset  = r_fpu_rst;
  assign fpu_op_a   = r_op_a;
  assign fpu_op_b   = r_op_b;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_status = r_out_status;
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_fpu_rst    <= 1'b0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_status <= '0;
    end else begin
      // every pop starts a one-cycle FPU reset pulse; LOAD never pops, so it releases it
      r_fpu_rst <= !w_pop;
      if (w_pop) {r_op_a, r_op_b} <= w_head;
      case (r_state)
        S_IDLE: if (w_pop) r_state <= S_LOAD;
        S_LOAD: begin
          r_state <= S_RUN;
          r_cnt   <= 8'(FPU_LATENCY - 1);
        end
        S_RUN:
          if (r_cnt == 8'd0) begin
            r_out_data   <= fpu_data;
            r_out_status <= fpu_status;
            r_out_valid  <= 1'b1;
            r_state      <= S_HOLD;
          end else r_cnt <= r_cnt - 8'd1;
        S_HOLD:
          if (w_hs) begin
            r_out_valid <= 1'b0;
            r_state     <= w_pop ? S_LOAD : S_IDLE;
          end
        default: r_state <= S_IDLE;
      endcase
    end
  end
`ifdef FPU_ISSUE_STICKY_EN
  logic [STATUS_W-1:0] r_sticky;
  assign sticky_status = r_sticky;
  always_ff @(posedge clock)
    if (!reset) r_sticky <= '0;
    else r_sticky <= (sticky_clr ? '0 : r_sticky) | (w_hs ? r_out_status : '0);
`endif
endmodule
